// File: rtl/imem_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : imem_dmem_port_arbiter
//  Description : Arbitrates one single-port unified memory between the IF
//                stage (fetch) and the MEM stage (load/store) of a 5-stage
//                pipeline. The data access is always served first, the
//                pipeline is frozen until every active request of the current
//                step has completed, and each access has an ack watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_dmem_port_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    input  logic        dm_rd_i,
    input  logic        dm_wr_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic [31:0] dm_rdata_o,
    output logic        stall_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        err_o
);

    localparam int                  c_CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0]  c_TIMEOUT = c_CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DM_WAIT = 2'd1,
        IF_WAIT = 2'd2
    } state_t;

    state_t               state_q,     state_d;
    logic [c_CNT_W-1:0]   cnt_q,       cnt_d;
    logic                 if_done_q,   if_done_d;
    logic                 dm_done_q,   dm_done_d;
    logic                 err_q,       err_d;
    logic                 mem_en_q,    mem_en_d;
    logic                 mem_we_q,    mem_we_d;
    logic [31:0]          mem_addr_q,  mem_addr_d;
    logic [31:0]          mem_wdata_q, mem_wdata_d;
    logic [31:0]          if_data_q,   if_data_d;
    logic [31:0]          dm_rdata_q,  dm_rdata_d;

    logic w_dm_pend;
    logic w_if_pend;
    logic w_release;
    logic w_timeout;

    // A request is pending when it is raised and not yet served in this step.
    assign w_dm_pend = (dm_rd_i | dm_wr_i) & ~dm_done_q;
    assign w_if_pend = if_req_i & ~if_done_q;
    assign stall_o   = start_i & (w_dm_pend | w_if_pend);
    // Release: the pipeline advances this edge, so the step's done flags reset.
    assign w_release = start_i & ~stall_o;
    assign w_timeout = (cnt_q == c_TIMEOUT);

    // Next-state logic: issue in IDLE (data first), complete on ack or watchdog.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        if_done_d   = if_done_q;
        dm_done_d   = dm_done_q;
        err_d       = err_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_data_d   = if_data_q;
        dm_rdata_d  = dm_rdata_q;

        if (w_release) begin
            if_done_d = 1'b0;
            dm_done_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // A release cycle has nothing pending, so no issue happens then.
                if (start_i) begin
                    if (w_dm_pend) begin
                        mem_en_d    = 1'b1;
                        mem_we_d    = dm_wr_i;
                        mem_addr_d  = dm_addr_i;
                        mem_wdata_d = dm_wdata_i;
                        cnt_d       = '0;
                        state_d     = DM_WAIT;
                    end else if (w_if_pend) begin
                        mem_en_d    = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr_i;
                        cnt_d       = '0;
                        state_d     = IF_WAIT;
                    end
                end
            end

            DM_WAIT, IF_WAIT: begin
                // An ack in the timeout cycle still counts as a normal completion.
                if (mem_ack_i || w_timeout) begin
                    state_d = IDLE;
                    if (!mem_ack_i) begin
                        err_d = 1'b1;
                    end
                    if (state_q == DM_WAIT) begin
                        dm_done_d = 1'b1;
                        // mem_we_q still holds the qualifier of this access.
                        if (!mem_we_q) begin
                            dm_rdata_d = mem_ack_i ? mem_rdata_i : 32'h0;
                        end
                    end else begin
                        if_done_d = 1'b1;
                        if_data_d = mem_ack_i ? mem_rdata_i : 32'h0;
                    end
                end else if (cnt_q != c_TIMEOUT) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            err_q       <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            if_data_q   <= 32'h0;
            dm_rdata_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
            err_q       <= err_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_data_q   <= if_data_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_data_o   = if_data_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_dmem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_imem_dmem_port_arbiter
//  Description : Self-checking bench for imem_dmem_port_arbiter. Each pipeline
//                step is predicted as a timeline (pulse, ack, completion and
//                release cycles) derived from the arbitration rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_dmem_port_arbiter;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = 32'h0;
    logic [31:0] if_data_o;
    logic        dm_rd_i = 1'b0;
    logic        dm_wr_i = 1'b0;
    logic [31:0] dm_addr_i = 32'h0;
    logic [31:0] dm_wdata_i = 32'h0;
    logic [31:0] dm_rdata_o;
    logic        stall_o;
    logic        mem_en_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = 32'h0;
    logic        mem_ack_i = 1'b0;
    logic        err_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected values of the sticky / holding outputs.
    logic [31:0] m_if_data  = 32'h0;
    logic [31:0] m_dm_rdata = 32'h0;
    logic        m_err      = 1'b0;

    imem_dmem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_data_o   (if_data_o),
        .dm_rd_i     (dm_rd_i),
        .dm_wr_i     (dm_wr_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_rdata_o  (dm_rdata_o),
        .stall_o     (stall_o),
        .mem_en_o    (mem_en_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // One pipeline step, entered at the start of its cycle 0. Ack latency
    // above TO means the memory never answers that access.
    task automatic run_step(input logic rd, input logic wr, input logic ifr,
                            input logic [31:0] da, input logic [31:0] wd,
                            input logic [31:0] ia,
                            input int l_dm, input int l_if,
                            input logic [31:0] rd_dm, input logic [31:0] rd_if,
                            input logic stale_ack);
        int   p_dm, p_if, a_dm, a_if, rel, t;
        logic dm;
        dm   = rd | wr;
        p_dm = -100; p_if = -100; a_dm = -100; a_if = -100;
        t    = 0;
        if (dm) begin
            p_dm = t + 1;
            if (l_dm <= TO) begin
                a_dm = p_dm + l_dm;
                t    = a_dm + 1;
                if (!wr) m_dm_rdata = rd_dm;
            end else begin
                t     = p_dm + TO + 1;
                m_err = 1'b1;
                if (!wr) m_dm_rdata = 32'h0;
            end
        end
        if (ifr) begin
            p_if = t + 1;
            if (l_if <= TO) begin
                a_if      = p_if + l_if;
                t         = a_if + 1;
                m_if_data = rd_if;
            end else begin
                t         = p_if + TO + 1;
                m_err     = 1'b1;
                m_if_data = 32'h0;
            end
        end
        rel = t;

        start_i    = 1'b1;
        dm_rd_i    = rd;
        dm_wr_i    = wr;
        if_req_i   = ifr;
        dm_addr_i  = da;
        dm_wdata_i = wd;
        if_addr_i  = ia;
        for (int k = 0; k <= rel; k++) begin
            mem_ack_i   = (k == a_dm) || (k == a_if) || (stale_ack && k == 0);
            mem_rdata_i = (k == a_dm) ? rd_dm : (k == a_if) ? rd_if : $urandom();
            @(negedge clk_i);
            check("stall", 32'(stall_o), 32'(k < rel));
            check("mem_en", 32'(mem_en_o), 32'((k == p_dm) || (k == p_if)));
            if (k == p_dm) begin
                check("dm_addr",  mem_addr_o, da);
                check("dm_we",    32'(mem_we_o), 32'(wr));
                check("dm_wdata", mem_wdata_o, wd);
            end
            if (k == p_if) begin
                check("if_addr", mem_addr_o, ia);
                check("if_we",   32'(mem_we_o), 32'h0);
            end
            if (k == rel) begin
                check("if_data",  if_data_o, m_if_data);
                check("dm_rdata", dm_rdata_o, m_dm_rdata);
                check("err",      32'(err_o), 32'(m_err));
            end
            next_cycle();
        end
        mem_ack_i = 1'b0;
    endtask

    task automatic random_steps(input int n);
        logic rd, wr, ifr;
        for (int i = 0; i < n; i++) begin
            rd  = 1'($urandom_range(0, 1));
            wr  = 1'($urandom_range(0, 1));
            ifr = 1'($urandom_range(0, 1));
            run_step(rd, wr, ifr, $urandom(), $urandom(), $urandom(),
                     int'($urandom_range(1, TO + 1)), int'($urandom_range(1, TO + 1)),
                     $urandom(), $urandom(), 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        // Reset held for two edges with requests present.
        rst_i     = 1'b0;
        start_i   = 1'b1;
        if_req_i  = 1'b1;
        dm_rd_i   = 1'b1;
        dm_addr_i = 32'h20;
        if_addr_i = 32'h08;
        for (int r = 0; r < 2; r++) begin
            next_cycle();
            @(negedge clk_i);
            check("rst_mem_en",  32'(mem_en_o), 32'h0);
            check("rst_mem_we",  32'(mem_we_o), 32'h0);
            check("rst_addr",    mem_addr_o, 32'h0);
            check("rst_wdata",   mem_wdata_o, 32'h0);
            check("rst_if_data", if_data_o, 32'h0);
            check("rst_dm_data", dm_rdata_o, 32'h0);
            check("rst_err",     32'(err_o), 32'h0);
        end
        next_cycle();
        rst_i = 1'b1;

        // Load @0x20 and fetch @0x08 together: DM pulse at 1, IF at 5, release 8.
        run_step(1'b1, 1'b0, 1'b1, 32'h20, 32'h0, 32'h08, 2, 2,
                 32'h55, 32'h20080005, 1'b0);
        // Fetch only @0x04.
        run_step(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h04, 2, 2,
                 32'h0, 32'h8C410004, 1'b0);
        // Store leaves dm_rdata at 0x55; both rd and wr high counts as a write.
        run_step(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 2, 2,
                 32'hA5A5A5A5, 32'h0, 1'b0);
        run_step(1'b1, 1'b1, 1'b0, 32'h14, 32'h12345678, 32'h0, 1, 1,
                 32'hFFFF0000, 32'h0, 1'b0);
        // Ack in the timeout cycle is a normal completion.
        run_step(1'b1, 1'b0, 1'b1, 32'h30, 32'h0, 32'h0C, TO, TO,
                 32'h0BADF00D, 32'h600DCAFE, 1'b0);

        // start_i low: no issue, no stall.
        start_i  = 1'b0;
        if_req_i = 1'b1;
        dm_rd_i  = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            check("nostart_stall",  32'(stall_o), 32'h0);
            check("nostart_mem_en", 32'(mem_en_o), 32'h0);
            next_cycle();
        end

        // Fetch with no ack: watchdog completion, if_data 0, err sticky.
        run_step(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h44, 1, TO + 1,
                 32'h0, 32'h0, 1'b0);

        random_steps(40);

        // Reset during DM_WAIT, stale ack right after reset is ignored.
        start_i   = 1'b1;
        dm_rd_i   = 1'b1;
        dm_wr_i   = 1'b0;
        if_req_i  = 1'b0;
        dm_addr_i = 32'h40;
        @(negedge clk_i);
        check("r6_stall0", 32'(stall_o), 32'h1);
        next_cycle();
        @(negedge clk_i);
        check("r6_pulse", 32'(mem_en_o), 32'h1);
        next_cycle();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("r6_stall_rst", 32'(stall_o), 32'h1);
        next_cycle();
        rst_i      = 1'b1;
        m_if_data  = 32'h0;
        m_dm_rdata = 32'h0;
        m_err      = 1'b0;
        run_step(1'b1, 1'b0, 1'b0, 32'h40, 32'h77, 32'h0, 3, 1,
                 32'hC0FFEE00, 32'h0, 1'b1);

        random_steps(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_dmem_port_arbiter.md
Name: imem_dmem_port_arbiter

Overview:
- Shares one single-port unified memory between the IF stage (instruction fetch) and the MEM stage (data load/store) of the 5-stage pipeline CPU.
- Serialises the two requests, with the data access first.
- Holds `stall_o` to freeze PC, IFID_Reg, IDEX_Reg, EX_MEM and MEM_WB until every active request of the current pipeline step has completed.
- Includes a per-access ack watchdog.

Parameters:
- TIMEOUT, 16, max cycles after a memory request pulse to wait for `mem_ack_i`; must be ≥1.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-low
- start_i  in  1  CPU run enable; 0 blocks new issues
- if_req_i  in  1  IF fetch request (level)
- if_addr_i  in  32  fetch address
- if_data_o  out  32  last fetched instruction (registered)
- dm_rd_i  in  1  MEM-stage load request (level)
- dm_wr_i  in  1  MEM-stage store request (level)
- dm_addr_i  in  32  data address
- dm_wdata_i  in  32  store data
- dm_rdata_o  out  32  last load data (registered)
- stall_o  out  1  pipeline freeze
- mem_en_o  out  1  one-cycle request pulse to memory (registered)
- mem_we_o  out  1  write qualifier for `mem_en_o` (registered)
- mem_addr_o  out  32  memory address (registered)
- mem_wdata_o  out  32  memory write data (registered)
- mem_rdata_i  in  32  memory read data, valid with `mem_ack_i`
- mem_ack_i  in  1  one-cycle completion pulse, at least 1 cycle after `mem_en_o`
- err_o  out  1  sticky watchdog error

Behaviour:
- Reset (`rst_i`=0 at an edge), regardless of other inputs:
  - state=IDLE; `if_done`, `dm_done`, counter, `err_o` cleared.
  - `mem_en_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `if_data_o`, `dm_rdata_o` = 0.
- Reset mid-transaction abandons the access. A subsequent `mem_ack_i` arriving in IDLE is ignored.
- `dm_req` = `dm_rd_i` | `dm_wr_i`. If both are high, it is treated as a write.
- `stall_o` (combinational) = `start_i` & ((`if_req_i` & ~`if_done`) | (`dm_req` & ~`dm_done`)).
- Release cycle: `start_i`=1 and `stall_o`=0.
  - At that edge `if_done` and `dm_done` clear and no access is issued.
  - Next cycle the advanced pipeline presents new requests.
- Requesters hold address, data and request stable while `stall_o`=1. The address is sampled at issue.
- FSM states: IDLE, DM_WAIT, IF_WAIT.
- IDLE, `start_i`=1, not a release cycle:
  - If `dm_req` & ~`dm_done`: register `mem_en_o`=1, `mem_we_o`=`dm_wr_i`, `mem_addr_o`=`dm_addr_i`, `mem_wdata_o`=`dm_wdata_i`; go to DM_WAIT.
  - Else if `if_req_i` & ~`if_done`: register `mem_en_o`=1, `mem_we_o`=0, `mem_addr_o`=`if_addr_i`; go to IF_WAIT.
  - Else stay.
  - DM always wins over IF.
- `mem_en_o` is high for exactly the first cycle of a WAIT state, then 0.
- `mem_addr_o` and `mem_wdata_o` hold until the next issue.
- In IDLE with `start_i`=0: no issue, `stall_o`=0.
- An outstanding WAIT completes even if `start_i` drops.
- DM_WAIT:
  - Counter starts at 0 in the pulse cycle and increments each cycle.
  - On `mem_ack_i`: `dm_done`=1; if the access was a read, `dm_rdata_o`=`mem_rdata_i` (a write leaves `dm_rdata_o` unchanged); go to IDLE.
- IF_WAIT: same as DM_WAIT, but sets `if_done` and loads `if_data_o`.
- Watchdog:
  - If no ack has arrived when the counter reaches TIMEOUT (i.e., at the end of cycle c+TIMEOUT, where c = pulse cycle), the access completes.
  - The corresponding data output is loaded with 32'h0 (reads only), `err_o`=1, state goes to IDLE.
- An ack in the same cycle as the timeout counts as a normal completion.
- Timing with ack 2 cycles after the pulse:
  - IF-only: issue decision at cycle 0, pulse at cycle 1, ack at cycle 3, release at cycle 4.
  - DM+IF: DM pulse at 1, ack at 3; IF pulse at 5, ack at 7; release at 8.
- Output data registers hold between completions.
- Counter width is `$clog2(TIMEOUT+1)` and saturates; no wrap.

Test Plan:
1. `rst_i`=0 for 2 cycles with `if_req_i`=1, `dm_rd_i`=1, `start_i`=1 → all outputs 0, `mem_en_o`=0; after `rst_i`=1 the DM pulse appears at the 2nd cycle.
2. IF-only, `if_addr_i`=0x04, memory acks 2 cycles after the pulse with 0x8C410004:
   - `mem_en_o`=1 with addr 0x04 and `mem_we_o`=0 at cycle 1.
   - `if_data_o`=0x8C410004 from cycle 4.
   - `stall_o`=1 during cycles 0–3, 0 at cycle 4.
3. `dm_rd_i`@0x20 and `if_req_i`@0x08 together, rdata 0x55 then 0x20080005:
   - Pulses at cycles 1 (0x20) and 5 (0x08).
   - `dm_rdata_o`=0x55, `if_data_o`=0x20080005.
   - `stall_o` high for cycles 0–7, low at cycle 8.
4. `dm_wr_i`=1, addr 0x10, wdata 0xDEADBEEF, with `dm_rdata_o` previously 0x55 → `mem_we_o`=1, `mem_wdata_o`=0xDEADBEEF, `dm_rdata_o` stays 0x55.
5. TIMEOUT=4, IF request, no ack → completion at end of cycle 5, `if_data_o`=0, `err_o`=1 until the next reset.
6. `rst_i`=0 in DM_WAIT, memory acks 1 cycle after release from reset → ack ignored, `dm_done`=0, a fresh DM pulse is issued, and `stall_o` remains asserted until its ack.
